// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for uart_rx: produces the mid-bit sampling ticks and buffers
// completed frames with their error flags in a small FIFO, alongside host status.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rxd,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_parity_err,
  input  logic       rx_stop_err,
  output logic       rx_baud_tick,
  output logic [7:0] m_data,
  output logic       m_perr,
  output logic       m_serr,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       overrun,
  output logic [7:0] parity_err_cnt,
  output logic [7:0] stop_err_cnt,
  input  logic       clear_status
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, HALF, BITS, WAIT_DONE} state_t;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] tick_cnt;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  // tick_cnt doubles as the rx_valid wait timer in WAIT_DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tick_cnt     <= '0;
      rx_baud_tick <= 1'b0;
    end else begin
      rx_baud_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !rxd) begin
            state    <= HALF;
            tick_cnt <= HALF_LOAD;
          end
        end
        HALF: begin
          if (tick_cnt == '0) begin
            rx_baud_tick <= 1'b1;
            bit_cnt      <= 4'd1;
            tick_cnt     <= FULL_LOAD;
            state        <= BITS;
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        BITS: begin
          if (tick_cnt == '0) begin
            rx_baud_tick <= 1'b1;
            if (bit_cnt == 4'd10) begin
              bit_cnt  <= '0;
              tick_cnt <= CW'(1);
              state    <= WAIT_DONE;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              tick_cnt <= FULL_LOAD;
            end
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        WAIT_DONE: begin
          if (rx_valid || tick_cnt == '0) begin
            state    <= IDLE;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  assign push_ok = rx_valid && (!full || pop);
  assign m_data  = mem[rd_ptr[AW-1:0]][7:0];
  assign m_perr  = mem[rd_ptr[AW-1:0]][8];
  assign m_serr  = mem[rd_ptr[AW-1:0]][9];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {rx_stop_err, rx_parity_err, rx_data};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A clear in the same cycle as an event wins, so that event is never counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      stop_err_cnt   <= '0;
    end else if (clear_status) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
      stop_err_cnt   <= '0;
    end else begin
      if (rx_valid && !push_ok) overrun <= 1'b1;
      if (rx_valid && rx_parity_err && parity_err_cnt != 8'hFF)
        parity_err_cnt <= parity_err_cnt + 8'd1;
      if (rx_valid && rx_stop_err && stop_err_cnt != 8'hFF)
        stop_err_cnt <= stop_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames and rx_valid pulses are checked every cycle
// against a frame-timing/queue model, with literal checks pinning key results.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_parity_err = 1'b0;
  logic       rx_stop_err = 1'b0;
  logic       m_ready = 1'b0;
  logic       clear_status = 1'b0;
  logic       rx_baud_tick;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_serr;
  logic       m_valid;
  logic       overrun;
  logic [7:0] parity_err_cnt;
  logic [7:0] stop_err_cnt;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_stop_err(rx_stop_err), .rx_baud_tick(rx_baud_tick),
    .m_data(m_data), .m_perr(m_perr), .m_serr(m_serr), .m_valid(m_valid),
    .m_ready(m_ready), .overrun(overrun), .parity_err_cnt(parity_err_cnt),
    .stop_err_cnt(stop_err_cnt), .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int last_start = 0;
  int tick_edges[$];
  bit check_on = 1'b0;
  bit random_mode = 1'b0;
  int tick_offsets[11] = '{8, 24, 40, 56, 72, 88, 104, 120, 136, 152, 168};

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  always @(posedge clk) cycle++;
  always @(negedge clk) if (rx_baud_tick) tick_edges.push_back(cycle);

  // Reference model: frame timing measured from the edge the line is seen low
  int         exp_edge = 0;
  int         exp_start = 0;
  bit         exp_in_frame = 1'b0;
  bit         exp_tick = 1'b0;
  logic [9:0] exp_q[$];
  bit         exp_overrun = 1'b0;
  int         exp_pcnt = 0;
  int         exp_scnt = 0;

  always @(posedge clk or posedge reset) begin
    int rel;
    if (reset) begin
      exp_in_frame = 1'b0;
      exp_tick     = 1'b0;
      exp_q.delete();
      exp_overrun  = 1'b0;
      exp_pcnt     = 0;
      exp_scnt     = 0;
    end else begin
      exp_edge++;
      exp_tick = 1'b0;
      if (exp_in_frame) begin
        rel = exp_edge - exp_start;
        if (rel >= CPB / 2 && rel <= CPB / 2 + 10 * CPB && (rel - CPB / 2) % CPB == 0)
          exp_tick = 1'b1;
        if ((rel == CPB / 2 + 10 * CPB + 1 && rx_valid) || rel == CPB / 2 + 10 * CPB + 2)
          exp_in_frame = 1'b0;
      end else if (enable && !rxd) begin
        exp_in_frame = 1'b1;
        exp_start    = exp_edge;
      end
      if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
      if (rx_valid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({rx_stop_err, rx_parity_err, rx_data});
        else exp_overrun = 1'b1;
      end
      if (clear_status) begin
        exp_overrun = 1'b0;
        exp_pcnt    = 0;
        exp_scnt    = 0;
      end else if (rx_valid) begin
        if (rx_parity_err && exp_pcnt < 255) exp_pcnt++;
        if (rx_stop_err && exp_scnt < 255) exp_scnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      checkOutput("rx_baud_tick", 8'(rx_baud_tick), 8'(exp_tick));
      checkOutput("m_valid", 8'(m_valid), 8'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        checkOutput("m_data", m_data, exp_q[0][7:0]);
        checkOutput("m_perr", 8'(m_perr), 8'(exp_q[0][8]));
        checkOutput("m_serr", 8'(m_serr), 8'(exp_q[0][9]));
      end
      checkOutput("overrun", 8'(overrun), 8'(exp_overrun));
      checkOutput("parity_err_cnt", parity_err_cnt, 8'(exp_pcnt));
      checkOutput("stop_err_cnt", stop_err_cnt, 8'(exp_scnt));
    end
  end

  always @(posedge clk) begin
    if (random_mode) begin
      #1;
      m_ready      = 1'($urandom_range(0, 1));
      clear_status = ($urandom_range(0, 63) == 0);
    end
  end

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  // Serial frame plus the uart_rx-style result pulse valid_delay cycles after the last tick
  task automatic applyStimulus(input logic [7:0] data, input bit perr, input bit serr,
                               input int valid_delay, input int gap);
    logic [10:0] frame_bits;
    frame_bits = {~serr, (^data) ^ perr, data, 1'b0};
    for (int i = 0; i < 11 * CPB; i++) begin
      if (i == 0) last_start = cycle + 1;
      if (i % CPB == 0) rxd = frame_bits[i / CPB];
      rx_valid = (valid_delay > 0 && i == CPB / 2 + 10 * CPB + valid_delay);
      if (rx_valid) begin
        rx_data       = data;
        rx_parity_err = perr;
        rx_stop_err   = serr;
      end
      tickClk();
    end
    rxd      = 1'b1;
    rx_valid = 1'b0;
    repeat (gap) tickClk();
  endtask

  task automatic pulseValid(input logic [7:0] data, input bit perr, input bit serr);
    rx_valid      = 1'b1;
    rx_data       = data;
    rx_parity_err = perr;
    rx_stop_err   = serr;
    tickClk();
    rx_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rx_baud_tick", 8'(rx_baud_tick), 8'h00);
    checkOutput("reset m_valid", 8'(m_valid), 8'h00);
    checkOutput("reset m_data", m_data, 8'h00);
    checkOutput("reset m_perr", 8'({m_perr, m_serr}), 8'h00);
    checkOutput("reset overrun", 8'(overrun), 8'h00);
    checkOutput("reset counters", parity_err_cnt | stop_err_cnt, 8'h00);
    reset    = 1'b0;
    check_on = 1'b1;
    repeat (4) tickClk();

    // Single frame: tick placement and captured contents
    tick_edges.delete();
    applyStimulus(8'h5A, 1'b0, 1'b0, 1, 20);
    checkOutput("single tick count", 8'(tick_edges.size()), 8'd11);
    for (int k = 0; k < 11 && k < tick_edges.size(); k++)
      checkOutput($sformatf("tick %0d offset", k), 8'(tick_edges[k] - last_start), 8'(tick_offsets[k]));
    checkOutput("single m_valid", 8'(m_valid), 8'h01);
    checkOutput("single m_data", m_data, 8'h5A);
    checkOutput("single flags", 8'({m_serr, m_perr}), 8'h00);
    m_ready = 1'b1;
    repeat (DEPTH + 1) tickClk();
    m_ready = 1'b0;

    // Back-to-back frames with no idle gap
    tick_edges.delete();
    applyStimulus(8'h01, 1'b0, 1'b0, 1, 0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1, 20);
    checkOutput("b2b tick count", 8'(tick_edges.size()), 8'd22);
    for (int k = 0; k + 1 < tick_edges.size(); k++)
      checkOutput($sformatf("b2b spacing %0d", k), 8'(tick_edges[k + 1] - tick_edges[k]), 8'd16);
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("b2b first", m_data, 8'h01);
    @(negedge clk);
    checkOutput("b2b second", m_data, 8'hFF);
    tickClk();
    m_ready = 1'b0;
    checkOutput("b2b drained", 8'(m_valid), 8'h00);

    // Overflow: five frames into a four-entry buffer
    for (int f = 0; f < 5; f++) applyStimulus(8'(8'h10 + f), 1'b0, 1'b0, 1, 5);
    checkOutput("overflow overrun", 8'(overrun), 8'h01);
    clear_status = 1'b1;
    tickClk();
    clear_status = 1'b0;
    @(negedge clk);
    checkOutput("clear overrun", 8'(overrun), 8'h00);
    checkOutput("clear keeps head", m_data, 8'h10);
    m_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      checkOutput($sformatf("overflow order %0d", f), m_data, 8'(8'h10 + f));
      @(negedge clk);
    end
    checkOutput("overflow drained", 8'(m_valid), 8'h00);
    tickClk();
    m_ready = 1'b0;

    // Error frame, then saturate the counters
    applyStimulus(8'h3C, 1'b1, 1'b1, 1, 20);
    checkOutput("err m_perr", 8'(m_perr), 8'h01);
    checkOutput("err m_serr", 8'(m_serr), 8'h01);
    checkOutput("err parity cnt", parity_err_cnt, 8'd1);
    checkOutput("err stop cnt", stop_err_cnt, 8'd1);
    m_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      pulseValid(8'(n), 1'b1, 1'b1);
      tickClk();
    end
    checkOutput("sat parity cnt", parity_err_cnt, 8'd255);
    checkOutput("sat stop cnt", stop_err_cnt, 8'd255);
    m_ready = 1'b0;
    repeat (400) tickClk();

    // Disabled: line held low must not start a frame
    tick_edges.delete();
    enable = 1'b0;
    rxd    = 1'b0;
    repeat (60) tickClk();
    checkOutput("disabled ticks", 8'(tick_edges.size()), 8'd0);
    rxd = 1'b1;
    tickClk();
    enable = 1'b1;

    // Randomized frames and standalone result pulses
    random_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      enable = ($urandom_range(0, 7) != 0);
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), $urandom_range(0, 30));
    end
    enable = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) pulseValid(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else tickClk();
    end
    random_mode = 1'b0;
    tickClk();
    tickClk();
    clear_status = 1'b0;
    m_ready      = 1'b0;
    repeat (400) tickClk();

    // Asynchronous reset in the middle of the data bits
    pulseValid(8'hA5, 1'b1, 1'b0);
    pulseValid(8'h5A, 1'b0, 1'b1);
    tick_edges.delete();
    rxd = 1'b0;
    repeat (80) tickClk();
    checkOutput("pre-reset ticks", 8'(tick_edges.size()), 8'd5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid reset tick", 8'(rx_baud_tick), 8'h00);
    checkOutput("mid reset m_valid", 8'(m_valid), 8'h00);
    checkOutput("mid reset parity cnt", parity_err_cnt, 8'h00);
    checkOutput("mid reset stop cnt", stop_err_cnt, 8'h00);
    rxd = 1'b1;
    repeat (2) tickClk();
    reset = 1'b0;
    tick_edges.delete();
    repeat (40) tickClk();
    checkOutput("post reset idle", 8'(tick_edges.size()), 8'd0);
    applyStimulus(8'hC3, 1'b0, 1'b0, 2, 10);
    checkOutput("post reset frame", m_data, 8'hC3);

    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencer and buffer for the UART receive datapath. Generates the bit-sampling tick stream for uart_rx: the first tick lands at the middle of the start bit, then one tick per bit period, 11 ticks per frame. Captures each completed frame and its error flags into a small FIFO with a ready/valid read port. Keeps sticky overrun status and saturating error counters for the host.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period (>=4)
FIFO_DEPTH, 4, frame buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = accept new frames; 0 = remain in IDLE with no ticks
rxd  input  1  serial line, same net that drives uart_rx
rx_data  input  8  uart_rx data_out
rx_valid  input  1  uart_rx valid_rx pulse
rx_parity_err  input  1  uart_rx parity_error
rx_stop_err  input  1  uart_rx stop_error
rx_baud_tick  output  1  sampling tick to uart_rx RX_baud_tick
m_data  output  8  FIFO head data
m_perr  output  1  FIFO head parity-error flag
m_serr  output  1  FIFO head stop-error flag
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts head
overrun  output  1  sticky: a frame was dropped because the FIFO was full
parity_err_cnt  output  8  saturating count of frames with parity error
stop_err_cnt  output  8  saturating count of frames with stop error
clear_status  input  1  clears overrun and both counters

Behaviour:
- Reset: FSM=IDLE; bit counter=0; tick counter=0; rx_baud_tick=0; FIFO empty; m_valid=0; m_data/m_perr/m_serr=0; overrun=0; both counters=0.
- FSM states:
  - IDLE
    - rxd==0 and enable==1 -> HALF, tick counter loads CLKS_PER_BIT/2-1.
    - Detection is level-based, matching uart_rx, which arms on the same cycle.
  - HALF
    - Count down to 0, then pulse rx_baud_tick for one cycle (start-bit sample).
    - Bit counter=1, tick counter loads CLKS_PER_BIT-1; -> BITS.
  - BITS
    - Count down; at 0, pulse tick, increment bit counter, reload.
    - After the tick with bit counter==10 (11th tick total) -> WAIT_DONE.
  - WAIT_DONE
    - Wait up to 2 cycles for rx_valid, then -> IDLE.
    - If rxd is still 0 in IDLE, a new frame starts immediately (back-to-back, or a stop error with the line held low).
- Tick spacing: first tick CLKS_PER_BIT/2 cycles after the cycle rxd is first seen low; subsequent ticks exactly CLKS_PER_BIT cycles apart. Exactly 11 ticks per frame, never more.
- enable deasserted mid-frame: the frame completes normally; the next frame is not started.
- FIFO
  - Push {rx_stop_err, rx_parity_err, rx_data} on rx_valid, in any state.
  - Pop when m_valid and m_ready. m_data/m_perr/m_serr show the head combinationally from storage.
  - Push while full: frame dropped, overrun<=1. Simultaneous pop and push while full: pop frees a slot and the push is accepted, no overrun.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty derived from the pointers.
- Counters: on an accepted or dropped rx_valid with the flag set, increment the corresponding counter; hold at 255. rx_valid with both flags set increments both.
- clear_status: overrun and counters <=0. If an event arrives the same cycle, clear wins and the event is not counted (frame still pushed if space).
- Async reset mid-frame: everything returns to reset values immediately; the partial frame is abandoned (uart_rx is reset by the same signal).

Test Plan:
- CLKS_PER_BIT=16; frame 0x5A, correct parity, stop=1 -> ticks at cycles 8,24,...,168 after rxd falls (11 total); m_valid=1, m_data=0x5A, m_perr=0, m_serr=0.
- Two back-to-back frames 0x01, 0xFF with no idle gap -> 22 ticks, correctly spaced; FIFO drains 0x01 then 0xFF with m_ready=1.
- FIFO_DEPTH=4, m_ready=0, send 5 frames -> first 4 retained in order, 5th dropped, overrun=1; clear_status -> overrun=0, FIFO contents unchanged.
- Frame with wrong parity and stop=0 -> m_perr=1, m_serr=1, both counters=1. 300 such frames -> both counters=255.
- enable=0 with rxd low -> no ticks, FSM stays IDLE. Assert reset in BITS after tick 5 -> rx_baud_tick=0, FSM=IDLE, FIFO empty, counters 0.
